// File: rtl/mio_bus_responder.sv
// Memory/IO-side responder for the multi-cycle CPU bus: captures one request,
// runs it against word RAM or the IO region with per-region wait states.
module mio_bus_responder #(
    parameter int         RAM_WAIT  = 1,
    parameter int         IO_WAIT   = 3,
    parameter logic [3:0] IO_NIBBLE = 4'hF,
    parameter int         RAM_AW    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic              cpu_mio,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mio_ready,
    output logic              bus_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic [27:0]       io_addr,
    output logic              io_we,
    output logic              io_rd,
    output logic [31:0]       io_din,
    input  logic [31:0]       io_dout
);

    localparam int MAX_WAIT = (RAM_WAIT > IO_WAIT) ? RAM_WAIT : IO_WAIT;
    localparam int CW       = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              is_io_q, is_io_d;
    logic              is_wr_q, is_wr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mio_ready_q, mio_ready_d;
    logic              bus_err_q, bus_err_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [31:0]       ram_din_q, ram_din_d;
    logic [27:0]       io_addr_q, io_addr_d;
    logic              io_we_q, io_we_d;
    logic              io_rd_q, io_rd_d;
    logic [31:0]       io_din_q, io_din_d;

    logic req, req_err, req_io, ram_lookahead;

    assign req     = cpu_mio & (mem_r | mem_w);
    assign req_err = (mem_r & mem_w) | (addr[1:0] != 2'b00);
    assign req_io  = (addr[31:28] == IO_NIBBLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_io_d     = is_io_q;
        is_wr_d     = is_wr_q;
        rdata_d     = rdata_q;
        mio_ready_d = 1'b0;
        bus_err_d   = bus_err_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = ram_we_q;
        ram_din_d   = ram_din_q;
        io_addr_d   = io_addr_q;
        io_we_d     = io_we_q;
        io_rd_d     = io_rd_q;
        io_din_d    = io_din_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    is_io_d = req_io;
                    is_wr_d = mem_w;
                    if (req_err) begin
                        state_d     = DONE;
                        mio_ready_d = 1'b1;
                        bus_err_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        if (req_io) begin
                            cnt_d     = CW'(IO_WAIT);
                            io_addr_d = addr[27:0];
                            io_din_d  = wdata;
                            io_we_d   = mem_w;
                            io_rd_d   = mem_r;
                        end else begin
                            cnt_d      = CW'(RAM_WAIT);
                            ram_addr_d = addr[RAM_AW+1:2];
                            ram_din_d  = wdata;
                            ram_we_d   = mem_w;
                        end
                    end
                end
            end
            ACCESS: begin
                ram_we_d = 1'b0;
                io_we_d  = 1'b0;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = DONE;
                    mio_ready_d = 1'b1;
                    bus_err_d   = 1'b0;
                    io_rd_d     = 1'b0;
                    if (!is_wr_q) begin
                        rdata_d = is_io_q ? io_dout : ram_dout;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_io_q     <= 1'b0;
            is_wr_q     <= 1'b0;
            rdata_q     <= '0;
            mio_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_din_q   <= '0;
            io_addr_q   <= '0;
            io_we_q     <= 1'b0;
            io_rd_q     <= 1'b0;
            io_din_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_io_q     <= is_io_d;
            is_wr_q     <= is_wr_d;
            rdata_q     <= rdata_d;
            mio_ready_q <= mio_ready_d;
            bus_err_q   <= bus_err_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_din_q   <= ram_din_d;
            io_addr_q   <= io_addr_d;
            io_we_q     <= io_we_d;
            io_rd_q     <= io_rd_d;
            io_din_q    <= io_din_d;
        end
    end

    // The sync RAM must see the read address at the capture edge so its data
    // is ready when a single-cycle access exits; afterwards the held copy drives it.
    assign ram_lookahead = (state_q == IDLE) & req & ~req_err & ~req_io;

    assign ram_addr  = ram_lookahead ? addr[RAM_AW+1:2] : ram_addr_q;
    assign rdata     = rdata_q;
    assign mio_ready = mio_ready_q;
    assign bus_err   = bus_err_q;
    assign ram_we    = ram_we_q;
    assign ram_din   = ram_din_q;
    assign io_addr   = io_addr_q;
    assign io_we     = io_we_q;
    assign io_rd     = io_rd_q;
    assign io_din    = io_din_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder with a behavioural sync RAM and a
// fixed IO read value; hand-computed expectations.
module tb_mio_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_r, mem_w, cpu_mio;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        mio_ready, bus_err;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic [27:0] io_addr;
    logic        io_we, io_rd;
    logic [31:0] io_din;
    logic [31:0] io_dout;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_cnt  = 0;
    int ram_we_cnt = 0;
    int io_we_cnt  = 0;
    int io_rd_cnt  = 0;

    logic [31:0] mem [0:1023];

    mio_bus_responder dut (
        .clk(clk), .reset(reset),
        .mem_r(mem_r), .mem_w(mem_w), .cpu_mio(cpu_mio),
        .addr(addr), .wdata(wdata), .rdata(rdata),
        .mio_ready(mio_ready), .bus_err(bus_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
        .io_addr(io_addr), .io_we(io_we), .io_rd(io_rd), .io_din(io_din), .io_dout(io_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
        if (mio_ready) rdy_cnt <= rdy_cnt + 1;
        if (ram_we)    ram_we_cnt <= ram_we_cnt + 1;
        if (io_we)     io_we_cnt <= io_we_cnt + 1;
        if (io_rd)     io_rd_cnt <= io_rd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents a one-cycle request at the current negedge; lat = negedges until
    // mio_ready is seen (0 if none within the budget). Returns in the ready cycle.
    task automatic request(input logic r, input logic w, input logic m,
                           input logic [31:0] a, input logic [31:0] d, output int lat);
        mem_r = r; mem_w = w; cpu_mio = m; addr = a; wdata = d;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin
                mem_r = 1'b0; mem_w = 1'b0; cpu_mio = 1'b0;
            end
            if (mio_ready) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat, s_ram_we, s_io_we, s_io_rd, s_rdy;

    initial begin
        reset = 1'b1; mem_r = 0; mem_w = 0; cpu_mio = 0; addr = 0; wdata = 0;
        io_dout = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready", {31'b0, mio_ready}, 32'h0);
        check("rst_strobes", {28'b0, ram_we, io_we, io_rd, bus_err}, 32'h0);
        check("rst_ram_addr", {22'b0, ram_addr}, 32'h0);
        check("rst_io_addr", {4'b0, io_addr}, 32'h0);
        check("rst_din", ram_din | io_din, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // RAM write RAM[4] = DEADBEEF
        s_ram_we = ram_we_cnt;
        request(0, 1, 1, 32'h0000_0010, 32'hDEAD_BEEF, lat);
        check("ram_wr_lat", lat, 2);
        check("ram_wr_err", {31'b0, bus_err}, 32'h0);
        check("ram_wr_rdata", rdata, 32'h0);
        check("ram_wr_pulses", ram_we_cnt - s_ram_we, 1);
        @(negedge clk);
        check("ready_one_cycle", {31'b0, mio_ready}, 32'h0);

        // RAM read 0x10
        request(1, 0, 1, 32'h0000_0010, 32'h0, lat);
        check("ram_rd_lat", lat, 2);
        check("ram_rd_data", rdata, 32'hDEAD_BEEF);
        check("ram_rd_err", {31'b0, bus_err}, 32'h0);
        @(negedge clk);
        check("rdata_held", rdata, 32'hDEAD_BEEF);

        // IO write 0xF000_0004 data 0x5A
        s_io_we = io_we_cnt; s_ram_we = ram_we_cnt;
        request(0, 1, 1, 32'hF000_0004, 32'h0000_005A, lat);
        check("io_wr_lat", lat, 4);
        check("io_wr_pulses", io_we_cnt - s_io_we, 1);
        check("io_wr_no_ram_we", ram_we_cnt - s_ram_we, 0);
        check("io_wr_addr", {4'b0, io_addr}, 32'h4);
        check("io_wr_din", io_din, 32'h5A);
        check("io_wr_rdata", rdata, 32'hDEAD_BEEF);
        @(negedge clk);

        // IO read 0xF000_0020
        s_io_rd = io_rd_cnt;
        request(1, 0, 1, 32'hF000_0020, 32'h0, lat);
        check("io_rd_lat", lat, 4);
        check("io_rd_data", rdata, 32'hCAFE_F00D);
        check("io_rd_cycles", io_rd_cnt - s_io_rd, 3);
        check("io_rd_addr", {4'b0, io_addr}, 32'h20);
        @(negedge clk);

        // Unaligned read -> error next cycle, no strobe, rdata unchanged
        s_ram_we = ram_we_cnt; s_io_we = io_we_cnt; s_io_rd = io_rd_cnt;
        request(1, 0, 1, 32'h0000_0002, 32'h0, lat);
        check("unal_lat", lat, 1);
        check("unal_err", {31'b0, bus_err}, 32'h1);
        check("unal_rdata", rdata, 32'hCAFE_F00D);
        @(negedge clk);
        // Both read and write -> error
        request(1, 1, 1, 32'hF000_0008, 32'h1, lat);
        check("rw_lat", lat, 1);
        check("rw_err", {31'b0, bus_err}, 32'h1);
        check("err_no_strobes", (ram_we_cnt - s_ram_we) + (io_we_cnt - s_io_we) + (io_rd_cnt - s_io_rd), 0);
        @(negedge clk);

        // cpu_mio = 0 -> no response
        s_rdy = rdy_cnt;
        request(1, 0, 0, 32'h0000_0010, 32'h0, lat);
        check("nomio_lat", lat, 0);
        check("nomio_ready", rdy_cnt - s_rdy, 0);

        // Aliased RAM read clears bus_err
        request(1, 0, 1, 32'h8000_1010, 32'h0, lat);
        check("alias_lat", lat, 2);
        check("alias_data", rdata, 32'hDEAD_BEEF);
        check("err_cleared", {31'b0, bus_err}, 32'h0);
        @(negedge clk);

        // Back-to-back: write 0x8 then read 0x8 presented in the DONE cycle
        request(0, 1, 1, 32'h0000_0008, 32'h1234_5678, lat);
        check("b2b_wr_lat", lat, 2);
        mem_r = 1'b1; cpu_mio = 1'b1; addr = 32'h0000_0008;
        @(negedge clk);
        check("b2b_idle_ready", {31'b0, mio_ready}, 32'h0);
        s_rdy = rdy_cnt;
        request(1, 0, 1, 32'h0000_0008, 32'h0, lat);
        check("b2b_rd_lat", lat, 2);
        check("b2b_rd_data", rdata, 32'h1234_5678);
        repeat (3) @(negedge clk);
        check("b2b_single_resp", rdy_cnt - s_rdy, 1);

        // Reset during an IO read access
        mem_r = 1'b1; cpu_mio = 1'b1; addr = 32'hF000_0010;
        @(negedge clk);
        mem_r = 1'b0; cpu_mio = 1'b0;
        check("abort_io_rd", {31'b0, io_rd}, 32'h1);
        @(negedge clk);
        s_rdy = rdy_cnt;
        reset = 1'b1;
        #1;
        check("abort_outputs", {27'b0, mio_ready, bus_err, ram_we, io_we, io_rd}, 32'h0);
        check("abort_rdata", rdata, 32'h0);
        check("abort_addr", {4'b0, io_addr} | {22'b0, ram_addr}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_ready", rdy_cnt - s_rdy, 0);
        request(1, 0, 1, 32'h0000_0010, 32'h0, lat);
        check("post_rst_lat", lat, 2);
        check("post_rst_data", rdata, 32'hDEAD_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
